trap_scheduler: RTL

TRAP_SCHEDULER -- requirements
Module: trap_scheduler

---
 rtl/trap_pkg.sv | 42 ++++
 rtl/trap_watchdog.sv | 36 +++
 rtl/trap_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap scheduler:
//   - trap_state_e : scheduler states (GUEST, ARMED, TRAPPED, EXIT)
//   - CAUSE_*      : 2-bit cause codes, also the pending-vector bit index
//   - highest_cause: fixed priority encoder, lowest code wins (io > sw > wdt > irq)
//   - cause_onehot : code -> pending-vector mask
// -----------------------------------------------------------------------------
package trap_pkg;

  typedef enum logic [1:0] {
    ST_GUEST   = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TRAPPED = 2'd2,
    ST_EXIT    = 2'd3
  } trap_state_e;

  localparam int NUM_CAUSES = 4;

  localparam logic [1:0] CAUSE_IO  = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;
  localparam logic [1:0] CAUSE_IRQ = 2'd3;

  // Priority follows the code value: the lowest set bit wins.
  function automatic logic [1:0] highest_cause(input logic [NUM_CAUSES-1:0] pend);
    logic [1:0] code;
    code = CAUSE_IO;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (pend[i]) code = 2'(i);
    end
    return code;
  endfunction

  function automatic logic [NUM_CAUSES-1:0] cause_onehot(input logic [1:0] code);
    logic [NUM_CAUSES-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/trap_watchdog.sv
// -----------------------------------------------------------------------------
// trap_watchdog
// Down-counter that counts guest M1 cycles and pulses expire on the 1->0 step.
// A reload value of 0 leaves the counter idle at 0, so it never expires.
//   clk, rst      : system clock, synchronous active-high reset
//   reload        : load reload_value into the counter
//   reload_value  : WDT_WIDTH-bit reload value
//   tick          : decrement request (one per counted M1 fall)
//   expire        : one-clk pulse when the counter steps from 1 to 0
// -----------------------------------------------------------------------------
module trap_watchdog #(
  parameter int WDT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reload,
  input  logic [WDT_WIDTH-1:0] reload_value,
  input  logic                 tick,
  output logic                 expire
);

  logic [WDT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (reload) begin
      count_reg <= reload_value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - WDT_WIDTH'(1);
    end
  end

  assign expire = tick && !reload && (count_reg == WDT_WIDTH'(1));

endmodule

// File: rtl/trap_scheduler.sv
// -----------------------------------------------------------------------------
// trap_scheduler
// Collects guest trap causes (I/O violation, hypercall, watchdog, intercepted
// IRQ) into sticky pending bits and walks the GUEST/ARMED/TRAPPED/EXIT
// sequence in step with Z80 M1 falls, raising NMI to enter the hypervisor.
//
// Optional feature macro: TRAP_WATCHDOG_EN -- when defined, a trap_watchdog
// counts M1 falls spent in GUEST and raises the wdt cause on expiry. When not
// defined, the wdt cause is never raised and wdt_reload is ignored.
//
// Ports
//   clk, rst             : system clock, synchronous active-high reset
//   m1_n                 : Z80 M1 (already synchronised to clk)
//   virtual_enabled      : virtualisation on
//   io_violation         : one-clk pulse, guest I/O violation   (cause 0)
//   sw_trap_req          : one-clk pulse, guest hypercall       (cause 1)
//   irq_req              : intercepted IRQ level                (cause 3)
//   new_isr              : decoder flag at M1 fall, NMI handler entered
//   last_isr_untrap      : decoder flag at M1 fall, handler returning to guest
//   cause_ack            : one-clk pulse, hypervisor has read the cause
//   wdt_reload           : watchdog reload value, 0 disables   (cause 2)
//   nmi_n                : NMI to the CPU, low only in ARMED while m1_n high
//   trap_state           : 1 in TRAPPED and EXIT
//   capture_address      : one M1 cycle wide strobe on trap entry / exit
//   cause_valid          : cause_code holds an unread cause
//   cause_code           : latched cause code
//   overrun              : io cause arrived while one was already pending
// -----------------------------------------------------------------------------
module trap_scheduler
  import trap_pkg::*;
#(
  parameter int WDT_WIDTH   = 16,
  parameter int IRQ_HOLDOFF = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m1_n,
  input  logic                 virtual_enabled,
  input  logic                 io_violation,
  input  logic                 sw_trap_req,
  input  logic                 irq_req,
  input  logic                 new_isr,
  input  logic                 last_isr_untrap,
  input  logic                 cause_ack,
  input  logic [WDT_WIDTH-1:0] wdt_reload,
  output logic                 nmi_n,
  output logic                 trap_state,
  output logic                 capture_address,
  output logic                 cause_valid,
  output logic [1:0]           cause_code,
  output logic                 overrun
);

  localparam int                IRQ_CW  = $clog2(IRQ_HOLDOFF + 1);
  localparam logic [IRQ_CW-1:0] IRQ_MAX = IRQ_CW'(IRQ_HOLDOFF);

  trap_state_e           state_reg, state_next;
  logic                  m1_prev_reg;
  logic [NUM_CAUSES-1:0] pending_reg, pending_next, pending_set, pending_clr;
  logic [1:0]            cause_code_reg, cause_code_next;
  logic                  cause_valid_reg, cause_valid_next;
  logic                  capture_reg, capture_next;
  logic                  overrun_reg, overrun_next;
  logic [IRQ_CW-1:0]     irq_cnt_reg, irq_cnt_next, irq_cnt_inc;

  logic       m1_fall;
  logic       accepting;
  logic       latch;
  logic       untrap;
  logic       exit_done;
  logic       irq_hit;
  logic [1:0] latch_code;
  logic       wdt_tick;
  logic       wdt_reload_en;
  logic       wdt_expire;

  assign m1_fall    = m1_prev_reg && !m1_n;
  assign accepting  = (state_reg == ST_GUEST) || (state_reg == ST_ARMED);
  assign latch      = m1_fall && (state_reg == ST_ARMED) && new_isr;
  assign untrap     = m1_fall && (state_reg == ST_TRAPPED) && last_isr_untrap && virtual_enabled;
  assign exit_done  = m1_fall && (state_reg == ST_EXIT);
  assign latch_code = highest_cause(pending_reg);

  assign wdt_tick      = m1_fall && (state_reg == ST_GUEST);
  assign wdt_reload_en = exit_done;

`ifdef TRAP_WATCHDOG_EN
  trap_watchdog #(
    .WDT_WIDTH (WDT_WIDTH)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .reload       (wdt_reload_en),
    .reload_value (wdt_reload),
    .tick         (wdt_tick),
    .expire       (wdt_expire)
  );
`else
  logic unused_wdt;
  assign unused_wdt = ^{wdt_reload, wdt_reload_en, wdt_tick};
  assign wdt_expire = 1'b0;
`endif

  // IRQ holdoff: count consecutive M1 falls with irq_req high, saturating at
  // IRQ_MAX; a fall with irq_req low restarts the count.
  assign irq_cnt_inc = (irq_cnt_reg == IRQ_MAX) ? IRQ_MAX : irq_cnt_reg + IRQ_CW'(1);
  assign irq_hit     = m1_fall && irq_req && (irq_cnt_inc == IRQ_MAX);

  always_comb begin
    irq_cnt_next = irq_cnt_reg;
    if (m1_fall) irq_cnt_next = irq_req ? irq_cnt_inc : '0;
  end

  always_comb begin
    pending_set            = '0;
    pending_set[CAUSE_IO]  = io_violation && accepting;
    pending_set[CAUSE_SW]  = sw_trap_req && accepting;
    pending_set[CAUSE_WDT] = wdt_expire;
    pending_set[CAUSE_IRQ] = irq_hit;
  end

  assign pending_clr = latch ? cause_onehot(latch_code) : '0;

  // A new event on the same clock as the latch of that cause stays pending.
  for (genvar gi = 0; gi < NUM_CAUSES; gi++) begin : g_pending
    assign pending_next[gi] = pending_set[gi] || (pending_reg[gi] && !pending_clr[gi]);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_GUEST: begin
        if (m1_fall && !virtual_enabled) state_next = ST_TRAPPED;
        else if (|pending_reg)           state_next = ST_ARMED;
      end
      ST_ARMED:   if (latch)     state_next = ST_TRAPPED;
      ST_TRAPPED: if (untrap)    state_next = ST_EXIT;
      ST_EXIT:    if (exit_done) state_next = ST_GUEST;
      default:                   state_next = ST_TRAPPED;
    endcase
  end

  always_comb begin
    capture_next     = capture_reg;
    cause_code_next  = cause_code_reg;
    cause_valid_next = cause_valid_reg;
    overrun_next     = overrun_reg;

    // Strobe spans exactly one M1 cycle: the next fall drops it unless that
    // same fall re-arms it.
    if (latch || untrap) capture_next = 1'b1;
    else if (m1_fall)    capture_next = 1'b0;

    if (latch) begin
      cause_code_next  = latch_code;
      cause_valid_next = 1'b1;
    end else if (cause_ack) begin
      cause_valid_next = 1'b0;
    end

    if (pending_set[CAUSE_IO] && pending_reg[CAUSE_IO]) overrun_next = 1'b1;
    else if (cause_ack)                                 overrun_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    m1_prev_reg <= m1_n;
    if (rst) begin
      state_reg       <= ST_TRAPPED;
      pending_reg     <= '0;
      cause_code_reg  <= CAUSE_IO;
      cause_valid_reg <= 1'b0;
      capture_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      irq_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      cause_code_reg  <= cause_code_next;
      cause_valid_reg <= cause_valid_next;
      capture_reg     <= capture_next;
      overrun_reg     <= overrun_next;
      irq_cnt_reg     <= irq_cnt_next;
    end
  end

  // NMI follows m1_n inside ARMED so it is only asserted between M1 cycles.
  assign nmi_n           = !((state_reg == ST_ARMED) && m1_n);
  assign trap_state      = (state_reg == ST_TRAPPED) || (state_reg == ST_EXIT);
  assign capture_address = capture_reg;
  assign cause_valid     = cause_valid_reg;
  assign cause_code      = cause_code_reg;
  assign overrun         = overrun_reg;

endmodule
